// File: rtl/shift_seq_pkg.sv
// Shared types and defaults for the multi-cycle shift sequencer.
// Optional sticky tracking is enabled with SHIFT_SEQ_STICKY_EN.
package shift_seq_pkg;

    localparam int unsigned SEQ_WIDTH = 8;
    localparam int unsigned SEQ_AMT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_LSL = 2'd0,
        MODE_LSR = 2'd1,
        MODE_ASR = 2'd2
    } mode_e;

    // la wins over lr; lr only selects direction for logical shifts
    function automatic mode_e mode_from(input logic la, input logic lr);
        mode_e m;
        if (la) begin
            m = MODE_ASR;
        end else if (lr) begin
            m = MODE_LSR;
        end else begin
            m = MODE_LSL;
        end
        return m;
    endfunction

endpackage

// File: rtl/shift_sequencer_stage.sv
// One-bit shift stage: combinational single-position shift with carry-out.
module shift_sequencer_stage
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             la_i,
    input  logic             lr_i,
    output logic [WIDTH-1:0] res_c_o,
    output logic             cout_c_o
);

    always_comb begin
        res_c_o  = a_i;
        cout_c_o = 1'b0;
        if (la_i) begin
            res_c_o  = {a_i[WIDTH-1], a_i[WIDTH-1:1]};
            cout_c_o = a_i[0];
        end else if (lr_i) begin
            res_c_o  = {1'b0, a_i[WIDTH-1:1]};
            cout_c_o = a_i[0];
        end else begin
            res_c_o  = {a_i[WIDTH-2:0], 1'b0};
            cout_c_o = a_i[WIDTH-1];
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: steps an accumulator through the one-bit stage.
// Define SHIFT_SEQ_STICKY_EN to track the OR of all shifted-out bits on sticky.
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int unsigned WIDTH = SEQ_WIDTH,
    parameter int unsigned AMT_W = SEQ_AMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    input  logic             la,
    input  logic             lr,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             zero,
    output logic             n,
    output logic             sticky
);

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic               cacc_q, cacc_d;
    logic [AMT_W-1:0]   rem_q, rem_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               c_q, c_d;
    logic               zero_q, zero_d;
    logic               n_q, n_d;

    logic               load_c;
    logic               step_c;
    logic               fin_c;
    logic [AMT_W-1:0]   amt_clamp_c;
    logic [WIDTH-1:0]   stage_res_c;
    logic               stage_cout_c;

    assign amt_clamp_c = (amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : amt;

    shift_sequencer_stage #(
        .WIDTH (WIDTH)
    ) u_stage (
        .a_i      (acc_q),
        .la_i     (mode_q == MODE_ASR),
        .lr_i     (mode_q == MODE_LSR),
        .res_c_o  (stage_res_c),
        .cout_c_o (stage_cout_c)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; a zero-distance request waits one cycle in DONE so done still lands one cycle after acceptance
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (amt_clamp_c == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem_q == AMT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control strobes; fin_c marks the edge that publishes the result
    always_comb begin
        load_c = 1'b0;
        step_c = 1'b0;
        fin_c  = 1'b0;
        case (state_q)
            IDLE: begin
                load_c = start;
            end
            SHIFT: begin
                step_c = 1'b1;
                fin_c  = (rem_q == AMT_W'(1));
            end
            DONE: begin
                fin_c = !done_q;
            end
            default: begin
                load_c = 1'b0;
            end
        endcase
    end

    // Datapath next values
    always_comb begin
        mode_d = mode_q;
        acc_d  = acc_q;
        cacc_d = cacc_q;
        rem_d  = rem_q;
        if (load_c) begin
            mode_d = mode_from(la, lr);
            acc_d  = a;
            cacc_d = 1'b0;
            rem_d  = amt_clamp_c;
        end else if (step_c) begin
            acc_d  = stage_res_c;
            cacc_d = stage_cout_c;
            rem_d  = rem_q - AMT_W'(1);
        end
    end

    // Result registers only move on the publishing edge
    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = fin_c;
        y_d    = y_q;
        c_d    = c_q;
        zero_d = zero_q;
        n_d    = n_q;
        if (fin_c) begin
            y_d    = acc_d;
            c_d    = cacc_d;
            zero_d = (acc_d == '0);
            n_d    = acc_d[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_LSL;
            acc_q  <= '0;
            cacc_q <= 1'b0;
            rem_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            y_q    <= '0;
            c_q    <= 1'b0;
            zero_q <= 1'b0;
            n_q    <= 1'b0;
        end else begin
            mode_q <= mode_d;
            acc_q  <= acc_d;
            cacc_q <= cacc_d;
            rem_q  <= rem_d;
            busy_q <= busy_d;
            done_q <= done_d;
            y_q    <= y_d;
            c_q    <= c_d;
            zero_q <= zero_d;
            n_q    <= n_d;
        end
    end

`ifdef SHIFT_SEQ_STICKY_EN
    logic sacc_q, sacc_d;
    logic sticky_q, sticky_d;

    always_comb begin
        sacc_d   = sacc_q;
        sticky_d = sticky_q;
        if (load_c) begin
            sacc_d = 1'b0;
        end else if (step_c) begin
            sacc_d = sacc_q | stage_cout_c;
        end
        if (fin_c) begin
            sticky_d = sacc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sacc_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            sacc_q   <= sacc_d;
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`else
    assign sticky = 1'b0;
`endif

    assign busy = busy_q;
    assign done = done_q;
    assign y    = y_q;
    assign c    = c_q;
    assign zero = zero_q;
    assign n    = n_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized self-checking bench for shift_sequencer against an arithmetic reference model.
module tb_shift_sequencer;

    localparam int unsigned W  = 8;
    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [AW-1:0] amt;
    logic          la;
    logic          lr;
    logic          busy;
    logic          done;
    logic [W-1:0]  y;
    logic          c;
    logic          zero;
    logic          n;
    logic          sticky;

    int checks   = 0;
    int failures = 0;

    shift_sequencer #(
        .WIDTH (W),
        .AMT_W (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .amt    (amt),
        .la     (la),
        .lr     (lr),
        .busy   (busy),
        .done   (done),
        .y      (y),
        .c      (c),
        .zero   (zero),
        .n      (n),
        .sticky (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: whole-distance shift computed directly, bits-out taken from the operand
    function automatic void model(input logic [7:0] av, input logic [3:0] amtv,
                                  input logic lav, input logic lrv,
                                  output logic [7:0] ey, output logic ec,
                                  output logic es, output int elat);
        int k;
        logic [15:0] ext;
        logic [7:0]  mask;
        k    = (int'(amtv) > 8) ? 8 : int'(amtv);
        elat = (k == 0) ? 1 : k;
        mask = 8'((16'd1 << k) - 16'd1);
        ec   = 1'b0;
        es   = 1'b0;
        if (lav) begin
            ext = {{8{av[7]}}, av};
            ey  = 8'(ext >> k);
            if (k > 0) ec = av[k-1];
            es  = |(av & mask);
        end else if (lrv) begin
            ey  = 8'(16'(av) >> k);
            if (k > 0) ec = av[k-1];
            es  = |(av & mask);
        end else begin
            ey  = 8'(16'(av) << k);
            if (k > 0) begin
                ec = av[8-k];
                es = |(16'(av) >> (8 - k));
            end
        end
`ifndef SHIFT_SEQ_STICKY_EN
        es = 1'b0;
`endif
    endfunction

    // One request; inject > 0 pulses a stray start that many cycles after acceptance
    task automatic run_op(input logic [7:0] a_v, input logic [3:0] amt_v,
                          input logic la_v, input logic lr_v, input int inject);
        logic [7:0] ey;
        logic       ec;
        logic       es;
        logic [7:0] y_prev;
        int         elat;
        int         lat;
        bit         busy_ok;
        bit         hold_ok;
        model(a_v, amt_v, la_v, lr_v, ey, ec, es, elat);
        @(negedge clk);
        a = a_v; amt = amt_v; la = la_v; lr = lr_v; start = 1'b1;
        @(posedge clk);
        #1;
        y_prev  = y;
        start   = 1'b0;
        a       = 8'($urandom);
        amt     = 4'($urandom);
        la      = 1'($urandom);
        lr      = 1'($urandom);
        lat     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!busy) busy_ok = 1'b0;
            if (start) start = 1'b0;
            if (done) break;
            if (y !== y_prev) hold_ok = 1'b0;
            if (lat == inject) begin
                start = 1'b1;
                a     = ~a_v;
                amt   = 4'd1;
                la    = 1'b0;
                lr    = 1'b0;
            end
        end
        check_eq("busy_during_op", 32'(busy_ok), 32'd1);
        check_eq("y_stable_during_op", 32'(hold_ok), 32'd1);
        check_eq("latency", 32'(lat), 32'(elat));
        check_eq("y", 32'(y), 32'(ey));
        check_eq("c", 32'(c), 32'(ec));
        check_eq("zero", 32'(zero), 32'(ey == 8'd0));
        check_eq("n", 32'(n), 32'(ey[7]));
        check_eq("sticky", 32'(sticky), 32'(es));
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", 32'(done), 32'd0);
        check_eq("busy_after_done", 32'(busy), 32'd0);
        check_eq("y_held", 32'(y), 32'(ey));
    endtask

    initial begin
        int  dones;
        bit  rst_ok;
        rst = 1'b1; start = 1'b0; a = '0; amt = '0; la = 1'b0; lr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_y", 32'(y), 32'd0);
        check_eq("rst_c", 32'(c), 32'd0);
        check_eq("rst_zero", 32'(zero), 32'd0);
        check_eq("rst_n", 32'(n), 32'd0);
        check_eq("rst_sticky", 32'(sticky), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(8'hB4, 4'd3, 1'b0, 1'b1, 0);
        run_op(8'h81, 4'd1, 1'b0, 1'b0, 0);
        run_op(8'h90, 4'd2, 1'b1, 1'($urandom), 0);
        run_op(8'h5A, 4'd0, 1'b0, 1'b1, 0);
        run_op(8'hFF, 4'd15, 1'b0, 1'b1, 0);
        run_op(8'h80, 4'd12, 1'b1, 1'b0, 0);

        // Stray start mid-operation must neither disturb nor queue
        run_op(8'hC3, 4'd4, 1'b0, 1'b1, 2);
        dones = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check_eq("no_queued_start", 32'(dones), 32'd0);
        run_op(8'h3C, 4'd2, 1'b0, 1'b0, 0);

        // Reset in the middle of a shift
        @(negedge clk);
        a = 8'hFF; amt = 4'd5; la = 1'b0; lr = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        rst_ok = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0 || y !== 8'h00 || c !== 1'b0) rst_ok = 1'b0;
        end
        check_eq("mid_op_reset_outputs", 32'(rst_ok), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (done || busy) dones++;
        end
        check_eq("mid_op_reset_idle", 32'(dones), 32'd0);
        run_op(8'h6D, 4'd5, 1'b0, 1'b1, 0);

        for (int i = 0; i < 40; i++) begin
            run_op(8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle shift controller placed directly upstream of the one-bit shift stage.
- Accepts an operand, a shift amount and a mode. Performs one single-bit shift per clock by feeding its accumulator through the one-bit stage, consuming that stage's result and carry each cycle.
- Returns the final result, last carry-out and status flags with a start/done handshake.
- Gives the datapath variable-distance shifts without a barrel shifter.

Parameters:
- WIDTH, 8, operand/result width in bits.
- AMT_W, 4, shift-amount width; must satisfy 2**AMT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand, captured on start acceptance.
- amt  input  AMT_W  shift distance, captured on start acceptance.
- la  input  1  1 = arithmetic right (lr ignored).
- lr  input  1  with la=0: 1 = logical right, 0 = logical left.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle completion pulse.
- y  output  WIDTH  result register.
- c  output  1  last bit shifted out.
- zero  output  1  y == 0.
- n  output  1  y[WIDTH-1].
- sticky  output  1  OR of every bit shifted out (see Optional Feature).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state = IDLE; busy, done, y, c, zero, n, sticky all 0.
- Step function, per mode:
  - la=0, lr=1: {0, acc[W-1:1]}, carry = acc[0].
  - la=0, lr=0: {acc[W-2:0], 0}, carry = acc[W-1].
  - la=1: {acc[W-1], acc[W-1:1]}, carry = acc[0].
- States: IDLE, SHIFT, DONE.
- IDLE with start=1: load acc=a, mode=(la,lr), rem=min(amt, WIDTH), cacc=0, sacc=0.
  - rem==0: next state DONE.
  - Otherwise: next state SHIFT.
- SHIFT, each cycle: acc=step(acc), cacc=carry, sacc|=carry, rem=rem-1. When rem==1 before decrement, next state is DONE.
- DONE, for one cycle:
  - done=1.
  - y=acc, c=cacc, zero/n/sticky updated in that same edge; they are visible with done.
  - Next state is IDLE.
- Latency: done is asserted max(rem,1) cycles after the start-acceptance edge.
  - busy=1 in SHIFT and DONE.
- y, c, zero, n and sticky hold their values until the next completion; they do not change during SHIFT.
- start while in SHIFT or DONE: ignored, with no queuing. Back-to-back requests need one IDLE cycle.
- amt > WIDTH is clamped to WIDTH:
  - Logical modes give y=0, c=last bit out.
  - Arithmetic mode gives all sign bits.
- a, amt, la and lr are don't-care outside the acceptance cycle.
- rst mid-operation takes priority over everything: state goes to IDLE, all outputs go to 0, and no done pulse is produced.

Optional Feature:
- Macro: SHIFT_SEQ_STICKY_EN.
- Defined: sacc is maintained and the sticky port reports the OR of all shifted-out bits of the last operation. amt=0 gives sticky=0.
- Undefined: no sacc register; sticky is tied to 0. The port is always present.

Decomposition:
- Shared package shift_seq_pkg:
  - State enum (IDLE, SHIFT, DONE).
  - Mode encodings (MODE_LSL, MODE_LSR, MODE_ASR).
  - Default WIDTH/AMT_W constants.
- Natural sub-module: the existing one-bit shifter stage, instantiated once.
  - acc drives A; the mode drives LA/LR; Y and C are captured.
  - No other sub-modules.

Test Plan:
- Reset: assert rst for 2 cycles mid-SHIFT (a=0xFF, amt=5) -> busy=0, y=0x00, c=0, no done pulse, state returns to IDLE.
- Logical right: a=0xB4, amt=3, la=0, lr=1 -> done 3 cycles after acceptance; y=0x16, c=1, zero=0, n=0, sticky=1 (macro on) / 0 (macro off).
- Logical left: a=0x81, amt=1, la=0, lr=0 -> done after 1 cycle; y=0x02, c=1, n=0.
- Arithmetic right: a=0x90, amt=2, la=1, lr=x -> y=0xE4, c=0, n=1, sticky=0.
- Boundaries:
  - a=0x5A, amt=0 -> done after 1 cycle, y=0x5A, c=0.
  - a=0xFF, amt=15, logical right -> clamped to 8, done after 8 cycles, y=0x00, c=1, zero=1.
- Handshake: pulse start again 2 cycles into a 4-bit shift with different a -> ignored; the first result is unchanged; a new start in the following IDLE is accepted normally.
